// File: rtl/uart_pkg.sv
// Shared types and frame-format helpers for the UART 16750 transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Stop length in baud ticks; 1.5 stop bits only exist for 5-bit words.
  function automatic int stop_ticks(input logic stb, input logic [1:0] wls, input int oversample);
    if (!stb) begin
      return oversample;
    end else if (wls == WLS_5) begin
      return oversample + (oversample / 2);
    end else begin
      return 2 * oversample;
    end
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - wls);
    if (sp) begin
      return ~eps;
    end else begin
      return (^(data & mask)) ^ ~eps;
    end
  endfunction

endpackage

// File: rtl/uart_tx_bitcnt.sv
// Baud tick counter with programmable terminal count; done pulses on the terminal tick.
module uart_tx_bitcnt #(
  parameter int CW = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] term,
  output logic          done
);

  logic [CW-1:0] cnt_r;

  assign done = tick & (cnt_r == term - CW'(1));

  // Count ticks, wrapping to zero on the terminal tick so the next state starts fresh.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= '0;
    end else if (clr || done) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 16750 transmit shifter: pops the TX FIFO and serialises start/data/parity/stop on SOUT.
// Optional auto-CTS flow control (AFE/CTSN ports) is enabled by defining UART_TX_AUTOCTS_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BAUDTICK,
  input  logic [1:0]       WLS,
  input  logic             STB,
  input  logic             PEN,
  input  logic             EPS,
  input  logic             SP,
  input  logic             BC,
`ifdef UART_TX_AUTOCTS_EN
  input  logic             AFE,
  input  logic             CTSN,
`endif
  input  logic [WIDTH-1:0] FIFO_Q,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_READ,
  output logic             SOUT,
  output logic             TX_BUSY,
  output logic             TEMT
);

  localparam int CW = $clog2(2 * OVERSAMPLE) + 1;
  localparam logic [CW-1:0] BIT_TICKS = CW'(OVERSAMPLE);

  tx_state_t     state_r, state_s;
  logic [7:0]    shreg_r, shreg_s;
  logic [2:0]    bitcnt_r, bitcnt_s;
  logic [2:0]    last_bit_s;
  logic [1:0]    wls_r;
  logic          stb_r, pen_r, par_r;
  logic          sout_r, sout_s, read_r, busy_r;
  logic          cts_ok_s, done_s, clr_s;
  logic [CW-1:0] term_s;

  if (WIDTH > 8) begin : g_hi
    logic unused_hi_s;
    assign unused_hi_s = ^FIFO_Q[WIDTH-1:8];
  end

`ifdef UART_TX_AUTOCTS_EN
  assign cts_ok_s = ~(AFE & CTSN);
`else
  assign cts_ok_s = 1'b1;
`endif

  assign last_bit_s = 3'(data_bits(wls_r) - 4'd1);
  assign term_s     = (state_r == STOP) ? CW'(stop_ticks(stb_r, wls_r, OVERSAMPLE)) : BIT_TICKS;
  assign clr_s      = (state_r == IDLE) || (state_r == LOAD);

  uart_tx_bitcnt #(.CW(CW)) u_bitcnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr_s),
    .tick (BAUDTICK),
    .term (term_s),
    .done (done_s)
  );

  // Next-state, shift register and bit counter; SOUT is derived from the next state so it lines up with it.
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    bitcnt_s = bitcnt_r;
    case (state_r)
      IDLE: begin
        if (!FIFO_EMPTY && cts_ok_s) state_s = LOAD;
        else                         state_s = IDLE;
      end
      LOAD: begin
        shreg_s  = FIFO_Q[7:0];
        bitcnt_s = 3'd0;
        state_s  = START;
      end
      START: begin
        if (done_s) state_s = DATA;
        else        state_s = START;
      end
      DATA: begin
        if (done_s) begin
          if (bitcnt_r == last_bit_s) begin
            bitcnt_s = 3'd0;
            state_s  = pen_r ? PARITY : STOP;
          end else begin
            bitcnt_s = bitcnt_r + 3'd1;
            shreg_s  = {1'b0, shreg_r[7:1]};
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (done_s) state_s = STOP;
        else        state_s = PARITY;
      end
      STOP: begin
        if (done_s) begin
          if (!FIFO_EMPTY && cts_ok_s) state_s = LOAD;
          else                         state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    case (state_s)
      START:   sout_s = 1'b0;
      DATA:    sout_s = shreg_s[0];
      PARITY:  sout_s = par_r;
      default: sout_s = 1'b1;
    endcase
  end

  // State and registered outputs; frame config and parity are frozen at LOAD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      shreg_r  <= 8'h00;
      bitcnt_r <= 3'd0;
      wls_r    <= 2'd0;
      stb_r    <= 1'b0;
      pen_r    <= 1'b0;
      par_r    <= 1'b0;
      sout_r   <= 1'b1;
      read_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      bitcnt_r <= bitcnt_s;
      sout_r   <= BC ? 1'b0 : sout_s;
      read_r   <= (state_s == LOAD);
      busy_r   <= (state_s != IDLE);
      if (state_r == LOAD) begin
        wls_r <= WLS;
        stb_r <= STB;
        pen_r <= PEN;
        par_r <= parity_bit(FIFO_Q[7:0], WLS, EPS, SP);
      end else begin
        wls_r <= wls_r;
        stb_r <= stb_r;
        pen_r <= pen_r;
        par_r <= par_r;
      end
    end
  end

  assign FIFO_READ = read_r;
  assign SOUT      = sout_r;
  assign TX_BUSY   = busy_r;
  assign TEMT      = FIFO_EMPTY & ~busy_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: per-tick frame model plus directed literal checks.
module tb_uart_tx_serializer;

  localparam int OS   = 16;
  localparam int LOGN = 8192;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BAUDTICK = 1'b0;
  logic [1:0] WLS = 2'd3;
  logic       STB = 1'b0, PEN = 1'b0, EPS = 1'b0, SP = 1'b0, BC = 1'b0;
`ifdef UART_TX_AUTOCTS_EN
  logic       AFE = 1'b0, CTSN = 1'b0;
`endif
  logic [7:0] FIFO_Q;
  logic       FIFO_EMPTY;
  logic       FIFO_READ, SOUT, TX_BUSY, TEMT;

  logic [7:0] fmem [0:15];
  int         wr = 0, rd = 0;
  int         checks = 0, errors = 0;
  logic       bc_d = 1'b0;
  logic       rd_prev = 1'b0;
  bit         exp_q [$];
  bit         tick_log [0:LOGN-1];
  int         log_n = 0, read_n = 0, cyc_n = 0;
  int         read_log [0:63];
  int         read_t [0:63];

  assign FIFO_Q     = fmem[rd % 16];
  assign FIFO_EMPTY = (wr == rd);

  uart_tx_serializer #(.WIDTH(8), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .BAUDTICK(BAUDTICK),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
`ifdef UART_TX_AUTOCTS_EN
    .AFE(AFE), .CTSN(CTSN),
`endif
    .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_READ(FIFO_READ),
    .SOUT(SOUT), .TX_BUSY(TX_BUSY), .TEMT(TEMT)
  );

  always #5 CLK = ~CLK;

  initial begin
    int div = 0;
    forever begin
      @(posedge CLK);
      #1;
      div = (div + 1) % 4;
      BAUDTICK = (div == 0);
    end
  end

  always @(posedge CLK) begin
    if (FIFO_READ) rd <= rd + 1;
    bc_d <= BC;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected SOUT for every baud tick of one frame, from the frame format rules.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] wls, input logic stb,
                             input logic pen, input logic eps, input logic sp);
    int nb, ones, nstop;
    bit par;
    nb = 5 + int'(wls);
    ones = 0;
    repeat (OS) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) begin
      if (sp)       par = !eps;
      else if (eps) par = (ones % 2) == 1;
      else          par = (ones % 2) == 0;
      repeat (OS) exp_q.push_back(par);
    end
    nstop = !stb ? OS : (wls == 2'd0 ? OS + OS / 2 : 2 * OS);
    repeat (nstop) exp_q.push_back(1'b1);
  endtask

  always @(negedge CLK) begin
    bit e;
    cyc_n++;
    if (RST) begin
      exp_q.delete();
      rd_prev = 1'b0;
    end else begin
      if (FIFO_READ) begin
        chk("read_nonempty", FIFO_EMPTY, 1'b0);
        chk("read_single", rd_prev, 1'b0);
        build_frame(FIFO_Q, WLS, STB, PEN, EPS, SP);
        if (read_n < 64) begin
          read_log[read_n] = log_n;
          read_t[read_n]   = cyc_n;
        end
        read_n++;
      end
      if (BAUDTICK && TX_BUSY && !FIFO_READ) begin
        if (log_n < LOGN) tick_log[log_n] = SOUT;
        log_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_len: tick beyond frame end, got 0 ticks left expected >0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sout_tick", SOUT, bc_d ? 1'b0 : e);
        end
      end
      if (!TX_BUSY) begin
        chk("sout_idle", SOUT, bc_d ? 1'b0 : 1'b1);
        chk("frame_done", exp_q.size(), 0);
        exp_q.delete();
      end
      chk("temt", TEMT, FIFO_EMPTY && !TX_BUSY);
      rd_prev = FIFO_READ;
    end
  end

  task automatic push(input logic [7:0] d);
    @(posedge CLK);
    #1;
    fmem[wr % 16] = d;
    wr++;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge CLK);
    while (!(!TX_BUSY && FIFO_EMPTY) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int n = 0;
    while (log_n < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_ticks: got %0d ticks expected %0d", log_n, target);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, output int base, output int nt);
    base = log_n;
    push(d);
    wait_done(4000);
    nt = log_n - base;
  endtask

  initial begin
    int base, nt, r0;
    logic [9:0] v;
    bit sp_t [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit eps_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit par_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge CLK);
    chk("rst_sout", SOUT, 1'b1);
    chk("rst_read", FIFO_READ, 1'b0);
    chk("rst_busy", TX_BUSY, 1'b0);
    chk("rst_temt", TEMT, 1'b1);
    @(posedge CLK); #1; RST = 1'b0;
    repeat (4) @(posedge CLK);

    // 8N1 frame of 0x55
    r0 = read_n;
    run_frame(8'h55, base, nt);
    chk("f55_ticks", nt, 160);
    chk("f55_reads", read_n - r0, 1);
    for (int j = 0; j < 10; j++) v[j] = tick_log[base + 16 * j + 8];
    chk("f55_bits", v, 10'b1010101010);
    chk("f55_temt", TEMT, 1'b1);

    // parity variants on 0x07
    PEN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      SP = sp_t[k];
      EPS = eps_t[k];
      run_frame(8'h07, base, nt);
      chk("par_ticks", nt, 176);
      chk("par_bit", tick_log[base + 152], par_t[k]);
    end
    PEN = 1'b0; SP = 1'b0; EPS = 1'b0;

    // 1.5 and 2 stop bits
    WLS = 2'd0; STB = 1'b1;
    run_frame(8'h1F, base, nt);
    chk("stop15_ticks", nt, 120);
    WLS = 2'd2;
    run_frame(8'h00, base, nt);
    chk("stop2_ticks", nt, 160);
    chk("stop2_lastdata", tick_log[base + 127], 1'b0);
    chk("stop2_first", tick_log[base + 128], 1'b1);
    WLS = 2'd3; STB = 1'b0;

    // back-to-back frames
    r0 = read_n;
    push(8'hA5); push(8'h3C); push(8'h81);
    wait_done(6000);
    chk("b2b_reads", read_n - r0, 3);
    chk("b2b_gap1", read_log[r0 + 1] - read_log[r0], 160);
    chk("b2b_gap2", read_log[r0 + 2] - read_log[r0 + 1], 160);
    chk("b2b_cycles", read_t[r0 + 2] - read_t[r0 + 1], 160 * 4);

    // break mid-DATA, frame keeps running
    base = log_n;
    push(8'h55);
    wait_ticks(base + 40, 1000);
    @(posedge CLK); #1; BC = 1'b1;
    repeat (3) @(negedge CLK);
    chk("brk_sout", SOUT, 1'b0);
    wait_ticks(base + 100, 1000);
    @(posedge CLK); #1; BC = 1'b0;
    wait_done(4000);
    chk("brk_ticks", log_n - base, 160);
    @(posedge CLK); #1; BC = 1'b1;
    repeat (3) @(negedge CLK);
    chk("brk_idle_sout", SOUT, 1'b0);
    @(posedge CLK); #1; BC = 1'b0;
    repeat (2) @(negedge CLK);
    chk("brk_idle_rel", SOUT, 1'b1);

    // reset mid-DATA
    base = log_n;
    push(8'h33);
    wait_ticks(base + 50, 1000);
    r0 = read_n;
    @(posedge CLK); #1; RST = 1'b1;
    #1;
    chk("midrst_sout", SOUT, 1'b1);
    chk("midrst_busy", TX_BUSY, 1'b0);
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("midrst_noread", read_n, r0);
    run_frame(8'h0F, base, nt);
    chk("midrst_recover", nt, 160);

`ifdef UART_TX_AUTOCTS_EN
    AFE = 1'b1; CTSN = 1'b1;
    r0 = read_n;
    push(8'h5A);
    repeat (1000) @(negedge CLK);
    chk("cts_hold_reads", read_n, r0);
    chk("cts_hold_busy", TX_BUSY, 1'b0);
    @(posedge CLK); #1; CTSN = 1'b0;
    @(negedge CLK);
    chk("cts_load", FIFO_READ, 1'b1);
    wait_done(4000);
    AFE = 1'b0;
`endif

    repeat (4) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
